// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit master: state encoding, widths and mode constants.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

   localparam int SPI_BYTE_W = 8;
   localparam int SPI_CNT_W  = 8;

   // Mode 0: SCK idles low. Data is presented before the first rising edge
   // and sampled on the rising edge.
   localparam logic CPOL = 1'b0;
   localparam logic CPHA = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOW,
      HIGH,
      WAIT,
      HOLD,
      GAP
   } spi_tx_state_t;

   // A phase lasting n cycles loads n-1 and leaves when the counter reads zero.
   function automatic logic [SPI_CNT_W-1:0] cnt_reload(input int n);
      return SPI_CNT_W'(n - 1);
   endfunction

endpackage

// File: rtl/spi_phase_cnt.sv
// Loadable 8-bit down-counter with a terminal-count flag, timing every SPI phase.
// Latency: load takes effect on the next clk. tc is combinational from the count register.
// Backpressure: none. The counter stops at zero until it is reloaded.
// Ports: clk/rst_n; load + load_val reload the count; cnt is the current count; tc = (cnt == 0).
module spi_phase_cnt
   import spi_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [SPI_CNT_W-1:0] load_val,
   output logic [SPI_CNT_W-1:0] cnt,
   output logic                 tc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/spi_tx_master.sv
// SPI mode-0 master transmitter: bytes from a valid/ready stream are shifted out MSB first under active-low SSEL.
// Latency: SSEL falls and MOSI=b7 one clk after accept. The first SCK rise follows SSEL_SETUP+CLK_DIV clks later.
// Backpressure: READY is high only in IDLE, in WAIT, and on the final SCK-high clk of a non-LAST byte.
// Ports: DATA/VALID/LAST/READY byte stream in; SCK/MOSI/SSEL SPI out (MISO unused);
//        BUSY = not idle, DONE = one-clk pulse as SSEL rises.
module spi_tx_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int SSEL_SETUP = 2,
   parameter int SSEL_HOLD  = 2,
   parameter int SSEL_GAP   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SPI_BYTE_W-1:0] DATA,
   input  logic                  VALID,
   input  logic                  LAST,
   output logic                  READY,
   output logic                  SCK,
   output logic                  MOSI,
   input  logic                  MISO,
   output logic                  SSEL,
   output logic                  BUSY,
   output logic                  DONE
);

   spi_tx_state_t         state;
   logic [SPI_BYTE_W-1:0] shreg;
   logic                  last_q;
   logic [2:0]            bit_idx;

   logic                  cnt_load;
   logic [SPI_CNT_W-1:0]  cnt_val;
   logic [SPI_CNT_W-1:0]  cnt;
   logic                  cnt_tc;
   logic                  accept;

   // MISO is reserved. It is only kept here so the port is not left dangling.
   logic                  unused_miso;
   assign unused_miso = MISO;

   assign accept = VALID && READY;

   // Every timed state is entered through a counter load. The reload value
   // is set by the state being entered.
   always_comb begin
      cnt_load = 1'b0;
      cnt_val  = cnt_reload(CLK_DIV);
      case (state)
         IDLE: begin
            cnt_load = accept;
            cnt_val  = cnt_reload(SSEL_SETUP);
         end
         SETUP, LOW: begin
            cnt_load = cnt_tc;
         end
         HIGH: begin
            cnt_load = cnt_tc;
            if (bit_idx == 3'd0 && last_q) begin
               cnt_val = cnt_reload(SSEL_HOLD);
            end
         end
         WAIT: begin
            cnt_load = accept;
         end
         HOLD: begin
            cnt_load = cnt_tc;
            cnt_val  = cnt_reload(SSEL_GAP);
         end
         default: begin
            cnt_load = 1'b0;
         end
      endcase
   end

   spi_phase_cnt u_phase_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .cnt      (cnt),
      .tc       (cnt_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         SSEL    <= 1'b1;
         SCK     <= CPOL;
         MOSI    <= 1'b0;
         READY   <= 1'b0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         shreg   <= '0;
         last_q  <= 1'b0;
         bit_idx <= 3'd0;
      end else begin
         DONE <= 1'b0;

         // Accepts happen only in IDLE, WAIT or the final HIGH clk of a
         // non-LAST byte. Each of them loads a fresh byte the same way.
         if (accept) begin
            shreg   <= DATA;
            last_q  <= LAST;
            MOSI    <= DATA[SPI_BYTE_W-1];
            bit_idx <= 3'd7;
            READY   <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (accept) begin
                  SSEL  <= 1'b0;
                  BUSY  <= 1'b1;
                  state <= SETUP;
               end else begin
                  READY <= 1'b1;
               end
            end

            SETUP: begin
               if (cnt_tc) begin
                  state <= LOW;
               end
            end

            LOW: begin
               if (cnt_tc) begin
                  SCK   <= ~CPOL;
                  state <= HIGH;
               end
            end

            HIGH: begin
               if (cnt_tc) begin
                  SCK <= CPOL;
                  if (bit_idx != 3'd0) begin
                     bit_idx <= bit_idx - 3'd1;
                     MOSI    <= shreg[bit_idx - 3'd1];
                     state   <= LOW;
                  end else if (last_q) begin
                     state <= HOLD;
                  end else if (accept) begin
                     state <= LOW;
                  end else begin
                     // READY stays high into WAIT.
                     state <= WAIT;
                  end
               end else if (bit_idx == 3'd0 && !last_q && cnt == 8'd1) begin
                  // READY is registered, so it is raised one clk early to be
                  // high during the final HIGH clk of bit 0.
                  READY <= 1'b1;
               end
            end

            WAIT: begin
               if (accept) begin
                  state <= LOW;
               end
            end

            HOLD: begin
               if (cnt_tc) begin
                  SSEL  <= 1'b1;
                  DONE  <= 1'b1;
                  state <= GAP;
               end
            end

            GAP: begin
               if (cnt_tc) begin
                  READY <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
